audio_mixer: RTL and testbench

- Mixes the per-card audio sources (SuperSprite PSG, Mockingboard L/R, Apple speaker) into the unsigned 16-bit left/right sample words consumed by audio_out.
- Sits between the card instances and audio_out in the board top and replaces the ad-hoc combinational sum.
- Adds a sample-rate strobe, per-source gain, speaker idle gating, saturation and sticky clip flags.
- Pipelined and registered on the pixel clock.

---
 rtl/audio_mixer.sv | 148 ++++++++++++++
 tb/tb_audio_mixer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_mixer.sv
// rtl/audio_mixer.sv - mixes SSP, Mockingboard and speaker audio into saturated 16-bit L/R sample words
module audio_mixer #(
    parameter int CLOCK_SPEED_HZ       = 27_000_000,
    parameter int SAMPLE_RATE          = 44100,
    parameter int SPEAKER_IDLE_SAMPLES = 4410
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ssp_audio_i,
    input  logic [9:0]  mb_audio_l_i,
    input  logic [9:0]  mb_audio_r_i,
    input  logic        speaker_i,
    input  logic        speaker_en_i,
    input  logic [1:0]  gain_ssp_i,
    input  logic [1:0]  gain_mb_i,
    input  logic        mute_i,
    input  logic        clear_clip_i,
    output logic [15:0] core_l_o,
    output logic [15:0] core_r_o,
    output logic        sample_valid_o,
    output logic        clip_l_o,
    output logic        clip_r_o
);

    localparam logic [31:0] CLK_HZ   = 32'(CLOCK_SPEED_HZ);
    localparam logic [31:0] RATE     = 32'(SAMPLE_RATE);
    localparam int          IW       = $clog2(SPEAKER_IDLE_SAMPLES + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(SPEAKER_IDLE_SAMPLES);

    // Fractional phase accumulator: SAMPLE_RATE strobes per CLOCK_SPEED_HZ cycles.
    logic [31:0] acc;
    logic [31:0] acc_sum;
    logic        strobe;

    assign acc_sum = acc + RATE;
    assign strobe  = (acc_sum >= CLK_HZ);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else begin
            acc <= strobe ? (acc_sum - CLK_HZ) : acc_sum;
        end
    end

    logic          spk_prev;
    logic [IW-1:0] idle_cnt;
    logic [IW-1:0] idle_next;
    logic          spk_on;

    always_comb begin
        idle_next = idle_cnt;
        if (speaker_i != spk_prev) begin
            idle_next = '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_next = idle_cnt + 1'b1;
        end
    end

    // The speaker term looks at the count including this sample's toggle decision.
    assign spk_on = speaker_i & speaker_en_i & (idle_next < IDLE_MAX);

    logic        s1_valid;
    logic [15:0] s1_ssp;
    logic [9:0]  s1_mb_l;
    logic [9:0]  s1_mb_r;
    logic [1:0]  s1_gain_ssp;
    logic [1:0]  s1_gain_mb;
    logic        s1_mute;
    logic        s1_spk_on;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_ssp      <= '0;
            s1_mb_l     <= '0;
            s1_mb_r     <= '0;
            s1_gain_ssp <= '0;
            s1_gain_mb  <= '0;
            s1_mute     <= 1'b0;
            s1_spk_on   <= 1'b0;
            spk_prev    <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            s1_valid <= strobe;
            if (strobe) begin
                s1_ssp      <= ssp_audio_i;
                s1_mb_l     <= mb_audio_l_i;
                s1_mb_r     <= mb_audio_r_i;
                s1_gain_ssp <= gain_ssp_i;
                s1_gain_mb  <= gain_mb_i;
                s1_mute     <= mute_i;
                s1_spk_on   <= spk_on;
                spk_prev    <= speaker_i;
                idle_cnt    <= idle_next;
            end
        end
    end

    logic [2:0]  mb_shift;
    logic [17:0] ssp_term;
    logic [17:0] mb_l_term;
    logic [17:0] mb_r_term;
    logic [17:0] spk_term;
    logic [17:0] sum_l;
    logic [17:0] sum_r;
    logic        over_l;
    logic        over_r;
    logic        clip_evt_l;
    logic        clip_evt_r;

    assign mb_shift   = {1'b0, s1_gain_mb} + 3'd3;
    assign ssp_term   = {2'b00, s1_ssp >> s1_gain_ssp};
    assign mb_l_term  = {8'b0, s1_mb_l} << mb_shift;
    assign mb_r_term  = {8'b0, s1_mb_r} << mb_shift;
    assign spk_term   = {4'b0, s1_spk_on, 13'b0};
    assign sum_l      = ssp_term + mb_l_term + spk_term;
    assign sum_r      = ssp_term + mb_r_term + spk_term;
    assign over_l     = (sum_l[17:16] != 2'b00);
    assign over_r     = (sum_r[17:16] != 2'b00);
    assign clip_evt_l = s1_valid & ~s1_mute & over_l;
    assign clip_evt_r = s1_valid & ~s1_mute & over_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_l_o       <= '0;
            core_r_o       <= '0;
            sample_valid_o <= 1'b0;
            clip_l_o       <= 1'b0;
            clip_r_o       <= 1'b0;
        end else begin
            sample_valid_o <= s1_valid;
            if (s1_valid) begin
                if (s1_mute) begin
                    core_l_o <= '0;
                    core_r_o <= '0;
                end else begin
                    core_l_o <= over_l ? 16'hFFFF : sum_l[15:0];
                    core_r_o <= over_r ? 16'hFFFF : sum_r[15:0];
                end
            end
            // A clip event in the same cycle as a clear keeps the flag set.
            clip_l_o <= clip_evt_l | (clip_l_o & ~clear_clip_i);
            clip_r_o <= clip_evt_r | (clip_r_o & ~clear_clip_i);
        end
    end

endmodule

// File: tb/tb_audio_mixer.sv
// tb/tb_audio_mixer.sv - scoreboard bench for audio_mixer with a scaled-down clock/sample ratio
module tb_audio_mixer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ssp_audio_i;
    logic [9:0]  mb_audio_l_i;
    logic [9:0]  mb_audio_r_i;
    logic        speaker_i;
    logic        speaker_en_i;
    logic [1:0]  gain_ssp_i;
    logic [1:0]  gain_mb_i;
    logic        mute_i;
    logic        clear_clip_i;
    logic [15:0] core_l_o;
    logic [15:0] core_r_o;
    logic        sample_valid_o;
    logic        clip_l_o;
    logic        clip_r_o;

    int          errors = 0;
    int          checks = 0;
    int          edge_cnt;
    logic [33:0] sb_q[$];
    bit          drv_done = 1'b0;

    always #5 clk = ~clk;

    // 2700 Hz / 441 Hz: first strobe in cycle 6, first sample_valid_o seen after edge 8.
    audio_mixer #(
        .CLOCK_SPEED_HZ       (2700),
        .SAMPLE_RATE          (441),
        .SPEAKER_IDLE_SAMPLES (4410)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ssp_audio_i    (ssp_audio_i),
        .mb_audio_l_i   (mb_audio_l_i),
        .mb_audio_r_i   (mb_audio_r_i),
        .speaker_i      (speaker_i),
        .speaker_en_i   (speaker_en_i),
        .gain_ssp_i     (gain_ssp_i),
        .gain_mb_i      (gain_mb_i),
        .mute_i         (mute_i),
        .clear_clip_i   (clear_clip_i),
        .core_l_o       (core_l_o),
        .core_r_o       (core_r_o),
        .sample_valid_o (sample_valid_o),
        .clip_l_o       (clip_l_o),
        .clip_r_o       (clip_r_o)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic set_in(input logic [15:0] ssp, input logic [1:0] gs, input logic [9:0] mbl,
                          input logic [9:0] mbr, input logic [1:0] gm, input logic mute,
                          input logic clr);
        ssp_audio_i  = ssp;
        gain_ssp_i   = gs;
        mb_audio_l_i = mbl;
        mb_audio_r_i = mbr;
        gain_mb_i    = gm;
        mute_i       = mute;
        clear_clip_i = clr;
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!sample_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!sample_valid_o) begin
            checks++;
            errors++;
            $display("FAIL sample_timeout: got no sample_valid_o in 20 cycles, required a pulse");
        end
    endtask

    task automatic sample(input logic [15:0] el, input logic [15:0] er, input logic ecl, input logic ecr);
        sb_q.push_back({el, er, ecl, ecr});
        wait_valid();
    endtask

    initial begin
        fork
            begin : monitor
                logic [33:0] exp;
                forever begin
                    @(negedge clk);
                    if (sample_valid_o) begin
                        checks++;
                        if (sb_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_sample: got l=%h r=%h, required no sample", core_l_o, core_r_o);
                        end else begin
                            exp = sb_q.pop_front();
                            if ({core_l_o, core_r_o, clip_l_o, clip_r_o} !== exp) begin
                                errors++;
                                if (errors <= 40)
                                    $display("FAIL sample: got l=%h r=%h cl=%b cr=%b, required l=%h r=%h cl=%b cr=%b",
                                             core_l_o, core_r_o, clip_l_o, clip_r_o,
                                             exp[33:18], exp[17:2], exp[1], exp[0]);
                            end
                        end
                    end
                end
            end
            begin : driver
                reset        = 1'b1;
                speaker_i    = 1'b0;
                speaker_en_i = 1'b0;
                set_in(16'h0, 2'd0, 10'h0, 10'h0, 2'd0, 1'b0, 1'b0);
                repeat (3) @(negedge clk);
                chk("reset_core_l", int'(core_l_o), 0);
                chk("reset_core_r", int'(core_r_o), 0);
                chk("reset_flags", int'({sample_valid_o, clip_l_o, clip_r_o}), 0);
                reset = 1'b0;

                // Strobe timing and pulse count with silent inputs.
                sample(16'h0, 16'h0, 1'b0, 1'b0);
                chk("first_valid_edge", edge_cnt, 8);
                for (int i = 1; i < 441; i++) sample(16'h0, 16'h0, 1'b0, 1'b0);
                chk("pulse_441_edge", edge_cnt, 2701);

                // Gains.
                set_in(16'h1000, 2'd1, 10'h3FF, 10'h001, 2'd2, 1'b0, 1'b0);
                sample(16'h87E0, 16'h0820, 1'b0, 1'b0);

                // Saturation and sticky clip.
                set_in(16'h8000, 2'd0, 10'h3FF, 10'h000, 2'd3, 1'b0, 1'b0);
                sample(16'hFFFF, 16'h8000, 1'b1, 1'b0);
                set_in(16'h1000, 2'd1, 10'h3FF, 10'h001, 2'd2, 1'b0, 1'b0);
                sample(16'h87E0, 16'h0820, 1'b1, 1'b0);
                set_in(16'h8000, 2'd0, 10'h3FF, 10'h000, 2'd3, 1'b0, 1'b1);
                sample(16'hFFFF, 16'h8000, 1'b1, 1'b0);
                set_in(16'h1000, 2'd1, 10'h3FF, 10'h001, 2'd2, 1'b0, 1'b1);
                sample(16'h87E0, 16'h0820, 1'b0, 1'b0);

                // Mute with clipping inputs on both channels.
                set_in(16'h8000, 2'd0, 10'h3FF, 10'h3FF, 2'd3, 1'b0, 1'b0);
                sample(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
                set_in(16'h8000, 2'd0, 10'h3FF, 10'h3FF, 2'd3, 1'b1, 1'b0);
                sample(16'h0000, 16'h0000, 1'b1, 1'b1);
                set_in(16'h8000, 2'd0, 10'h3FF, 10'h3FF, 2'd3, 1'b1, 1'b1);
                sample(16'h0000, 16'h0000, 1'b0, 1'b0);
                set_in(16'h8000, 2'd0, 10'h3FF, 10'h3FF, 2'd3, 1'b1, 1'b0);
                sample(16'h0000, 16'h0000, 1'b0, 1'b0);
                set_in(16'h8000, 2'd0, 10'h3FF, 10'h3FF, 2'd3, 1'b0, 1'b0);
                sample(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);

                // Speaker: toggle every 50 samples, then hold high until idle gating.
                set_in(16'h0100, 2'd0, 10'h0, 10'h0, 2'd0, 1'b0, 1'b1);
                speaker_en_i = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    speaker_i = (b % 2 == 0);
                    for (int k = 0; k < 50; k++) begin
                        if (b % 2 == 0) sample(16'h2100, 16'h2100, 1'b0, 1'b0);
                        else            sample(16'h0100, 16'h0100, 1'b0, 1'b0);
                    end
                end
                speaker_i = 1'b1;
                for (int k = 0; k < 4415; k++) begin
                    if (k < 4410) sample(16'h2100, 16'h2100, 1'b0, 1'b0);
                    else          sample(16'h0100, 16'h0100, 1'b0, 1'b0);
                end

                // Asynchronous reset clears non-zero outputs mid-cycle.
                reset = 1'b1;
                #1;
                chk("async_reset_core_l", int'(core_l_o), 0);
                chk("async_reset_core_r", int'(core_r_o), 0);
                @(negedge clk);
                speaker_i    = 1'b0;
                speaker_en_i = 1'b0;
                set_in(16'h1000, 2'd1, 10'h3FF, 10'h001, 2'd2, 1'b0, 1'b0);
                @(negedge clk);
                reset = 1'b0;

                // Reset with a sample in stage 1: it must be discarded.
                for (int n = 0; n < 20 && edge_cnt < 7; n++) @(negedge clk);
                chk("inflight_edge", edge_cnt, 7);
                reset = 1'b1;
                #1;
                chk("inflight_valid", int'(sample_valid_o), 0);
                chk("inflight_core_l", int'(core_l_o), 0);
                @(negedge clk);
                @(negedge clk);
                reset = 1'b0;
                sample(16'h87E0, 16'h0820, 1'b0, 1'b0);
                chk("restart_valid_edge", edge_cnt, 8);

                repeat (3) @(negedge clk);
                chk("scoreboard_empty", sb_q.size(), 0);
                drv_done = 1'b1;
            end
            begin : watchdog
                repeat (60000) @(negedge clk);
                if (!drv_done) begin
                    checks++;
                    errors++;
                    $display("FAIL watchdog: got driver still running after 60000 cycles, required completion");
                end
            end
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
